dino_motion_ctrl: RTL and testbench
===================================

Name: dino_motion_ctrl

Overview:
- Per-frame dino motion engine sitting directly upstream of the VGA controller.
- Consumes the up/down push-buttons and the controller's screenEnd frame strobe.
- Produces dino_x/dino_y (32-bit, matching the controller's inputs) plus status flags.
- Implements the jump/fall/duck state machine with integer gravity; the position is updated exactly once per video frame.

Parameters:
- DINO_X, 40, fixed horizontal position driven on dino_x
- GROUND_Y, 275, dino top-edge y when standing (ground line 335 minus 60-px sprite)
- MIN_Y, 0, ceiling clamp for dino_y
- JUMP_V, 12, initial upward speed in px/frame
- GRAVITY, 1, velocity increment per frame
- FASTFALL, 2, extra velocity increment per frame while down is held airborne

Ports:
- clk  in  1  100 MHz system clock, the single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  screenEnd from the VGA controller; high for 4 clk cycles (one clk25 cycle) per frame
- up  in  1  raw jump button, asynchronous
- down  in  1  raw duck button, asynchronous
- dino_x  out  32  always DINO_X
- dino_y  out  32  current dino top-edge y, unsigned, zero-extended
- airborne  out  1  high in RISE or FALL
- ducking  out  1  high in DUCK
- landed  out  1  one-clk pulse on the frame update that returns the dino to ground

Behaviour:
- Reset (async): dino_y=GROUND_Y, vel=0, state=GROUND, airborne=0, ducking=0, landed=0, jump_pend=0, all sync flops 0. Reset mid-jump aborts the jump immediately.
- Synchronisers: up and down each pass through a 2-flop synchroniser (up_s, down_s); effective latency is 2 clk.
- Frame pulse: ft_d <= frame_tick; frame_pulse = frame_tick & ~ft_d. There is exactly one pulse per frame regardless of the 4-cycle strobe width. All motion updates occur on the clk edge where frame_pulse=1. Outputs change one clk after frame_tick rises.
- Jump request:
  - jump_pend sets on any clk where up_s=1.
  - It is consumed and cleared on every frame_pulse.
  - Set and clear in the same cycle: clear wins; the up_s sample is lost only if up_s falls on that same edge.
- vel: signed 8-bit register. Position math uses signed 12-bit: ny = y + vel.
- States (transitions evaluated only on frame_pulse):
  - GROUND: if jump_pend -> RISE with y=GROUND_Y-JUMP_V and vel=-JUMP_V+GRAVITY. Else if down_s -> DUCK. Else stay. Up has priority over down.
  - DUCK: y held at GROUND_Y. jump_pend -> RISE (same as GROUND). Else if !down_s -> GROUND.
  - RISE:
    - y<=ny; vel<=vel+GRAVITY+(down_s?FASTFALL:0).
    - If ny<MIN_Y: y<=MIN_Y, vel<=0.
    - When the updated vel>=0 -> FALL.
  - FALL:
    - If ny>=GROUND_Y: y<=GROUND_Y, vel<=0, landed=1 for that cycle. Next state is DUCK if down_s, else GROUND.
    - Otherwise y<=ny; vel<=vel+GRAVITY+(down_s?FASTFALL:0).
- up is ignored while airborne; there is no double jump. jump_pend is still cleared each frame, so a press held through landing re-jumps on the next frame.
- Outputs are registered: airborne/ducking decode the state register; dino_y is never outside [MIN_Y, GROUND_Y].
- frame_tick held high continuously produces only one update; a new update requires frame_tick to fall and rise again.

Test Plan:
- Assert reset mid-run, release -> dino_y=275, dino_x=40, airborne=0, ducking=0, landed=0; 10 frames with no buttons -> dino_y stays 275.
- Pulse up for 3 clk, then frames with defaults:
  - dino_y sequence 263, 252, 242, … reaches 197 at frames 12 and 13.
  - Returns to 275 on frame 25 with landed high for exactly 1 clk.
  - airborne high for frames 1-24.
- Hold frame_tick high for 4 clk every 16 clk -> exactly one dino_y step per strobe; hold frame_tick high 100 clk -> exactly one step.
- Hold down on ground 2 frames -> ducking=1, dino_y=275. Press up while down is held -> jump starts (dino_y=263) next frame.
- Jump, then hold down from frame 3 -> fast-fall: velocity grows by 3/frame; landing occurs before frame 25, lands into DUCK, ducking=1.
- Assert reset at frame 6 of a jump -> dino_y=275 and state GROUND asynchronously (before the next clk edge); the next jump behaves as in scenario 2.

Source files
------------

// File: rtl/dino_motion_ctrl.sv
// dino_motion_ctrl: per-frame jump/fall/duck motion engine feeding dino position to the VGA controller
module dino_motion_ctrl #(
    parameter int DINO_X   = 40,
    parameter int GROUND_Y = 275,
    parameter int MIN_Y    = 0,
    parameter int JUMP_V   = 12,
    parameter int GRAVITY  = 1,
    parameter int FASTFALL = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        up,
    input  logic        down,
    output logic [31:0] dino_x,
    output logic [31:0] dino_y,
    output logic        airborne,
    output logic        ducking,
    output logic        landed
);
    typedef enum logic [1:0] {GROUND, DUCK, RISE, FALL} state_t;

    localparam logic signed [11:0] GND_S    = 12'(GROUND_Y);
    localparam logic signed [11:0] MIN_S    = 12'(MIN_Y);
    localparam logic        [9:0]  GND_Y10  = 10'(GROUND_Y);
    localparam logic        [9:0]  MIN_Y10  = 10'(MIN_Y);
    localparam logic        [9:0]  JUMP_Y10 = 10'(GROUND_Y - JUMP_V);
    localparam logic signed [7:0]  GRAV_V   = 8'(GRAVITY);
    localparam logic signed [7:0]  FF_V     = 8'(FASTFALL);
    localparam logic signed [7:0]  LAUNCH_V = 8'(GRAVITY - JUMP_V);

    state_t             state;
    logic        [9:0]  y;
    logic signed [7:0]  vel;
    logic signed [7:0]  nv;
    logic signed [11:0] ny;
    logic               up_m, up_s, down_m, down_s, ft_d, jump_pend;
    logic               frame_pulse;

    assign frame_pulse = frame_tick & ~ft_d;
    assign ny          = $signed({2'b00, y}) + $signed({{4{vel[7]}}, vel});
    assign nv          = vel + GRAV_V + (down_s ? FF_V : 8'sd0);
    assign dino_x      = 32'(DINO_X);
    assign dino_y      = {22'b0, y};

    // button synchronisers, frame edge detect and the latched jump request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {up_m, up_s, down_m, down_s, ft_d, jump_pend} <= '0;
        end else begin
            up_m      <= up;
            up_s      <= up_m;
            down_m    <= down;
            down_s    <= down_m;
            ft_d      <= frame_tick;
            jump_pend <= frame_pulse ? 1'b0 : (jump_pend | up_s);
        end
    end

    // motion state machine, stepped once per frame, with registered status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= GROUND;
            y        <= GND_Y10;
            vel      <= '0;
            airborne <= 1'b0;
            ducking  <= 1'b0;
            landed   <= 1'b0;
        end else begin
            landed <= 1'b0;
            if (frame_pulse) begin
                case (state)
                    GROUND, DUCK: begin
                        if (jump_pend) begin
                            state    <= RISE;
                            y        <= JUMP_Y10;
                            vel      <= LAUNCH_V;
                            airborne <= 1'b1;
                            ducking  <= 1'b0;
                        end else begin
                            state   <= down_s ? DUCK : GROUND;
                            ducking <= down_s;
                        end
                    end
                    RISE: begin
                        if (ny < MIN_S) begin
                            y     <= MIN_Y10;
                            vel   <= '0;
                            state <= FALL;
                        end else begin
                            y   <= ny[9:0];
                            vel <= nv;
                            if (!nv[7]) state <= FALL;
                        end
                    end
                    default: begin
                        if (ny >= GND_S) begin
                            y        <= GND_Y10;
                            vel      <= '0;
                            landed   <= 1'b1;
                            airborne <= 1'b0;
                            ducking  <= down_s;
                            state    <= down_s ? DUCK : GROUND;
                        end else begin
                            y   <= ny[9:0];
                            vel <= nv;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dino_motion_ctrl.sv
// tb_dino_motion_ctrl: vector table, corner-case sequences and random stimulus against a frame-level model
module tb_dino_motion_ctrl;
    localparam int GND = 275;
    localparam int JV  = 12;
    localparam int GR  = 1;
    localparam int FF  = 2;
    localparam int M_GROUND = 0, M_DUCK = 1, M_RISE = 2, M_FALL = 3;

    logic        clk = 0, reset = 1, frame_tick = 0, up = 0, down = 0;
    logic [31:0] dino_x, dino_y;
    logic        airborne, ducking, landed;

    dino_motion_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .up(up), .down(down),
        .dino_x(dino_x), .dino_y(dino_y), .airborne(airborne), .ducking(ducking), .landed(landed)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // frame-level reference: buttons seen two clocks late, one update per rising strobe
    int m_y = GND, m_v = 0, m_mode = M_GROUND, m_land = 0, m_pend = 0;
    int uh0 = 0, uh1 = 0, dh0 = 0, dh1 = 0, ft_prev = 0;

    task automatic model_edge();
        int ny, us, ds;
        if (reset) begin
            m_y = GND; m_v = 0; m_mode = M_GROUND; m_land = 0; m_pend = 0;
            uh0 = 0; uh1 = 0; dh0 = 0; dh1 = 0; ft_prev = 0;
        end else begin
            us = uh1; ds = dh1;
            m_land = 0;
            if (frame_tick && !ft_prev) begin
                if (m_mode == M_GROUND || m_mode == M_DUCK) begin
                    if (m_pend != 0) begin
                        m_y = GND - JV; m_v = GR - JV; m_mode = M_RISE;
                    end else m_mode = ds ? M_DUCK : M_GROUND;
                end else begin
                    ny = m_y + m_v;
                    if (m_mode == M_FALL && ny >= GND) begin
                        m_y = GND; m_v = 0; m_land = 1; m_mode = ds ? M_DUCK : M_GROUND;
                    end else if (ny < 0) begin
                        m_y = 0; m_v = 0; m_mode = M_FALL;
                    end else begin
                        m_y = ny; m_v = m_v + GR + ds * FF;
                        if (m_v >= 0) m_mode = M_FALL;
                    end
                end
                m_pend = 0;
            end else if (us != 0) m_pend = 1;
            uh1 = uh0; uh0 = int'(up); dh1 = dh0; dh0 = int'(down); ft_prev = int'(frame_tick);
        end
    endtask

    always @(posedge clk or posedge reset) model_edge();

    task automatic run_frame(input int hi, output int lcnt, output int ycnt);
        int prev;
        prev = int'(dino_y); lcnt = 0; ycnt = 0;
        frame_tick = 1;
        for (int i = 0; i < hi + 12; i++) begin
            if (i == hi) frame_tick = 0;
            @(negedge clk);
            lcnt += int'(landed);
            if (int'(dino_y) != prev) ycnt++;
            prev = int'(dino_y);
        end
    endtask

    task automatic step(input bit u, input bit d, output int lcnt, output int ycnt);
        down = d;
        if (u) begin
            up = 1;
            repeat (3) @(negedge clk);
            up = 0;
        end
        repeat (4) @(negedge clk);
        run_frame(4, lcnt, ycnt);
    endtask

    typedef struct {
        bit up;
        bit dn;
        int y;
        bit air;
        bit duck;
        int land;
    } vec_t;

    vec_t tbl[$];
    int   jy[25] = '{263, 252, 242, 233, 225, 218, 212, 207, 203, 200, 198, 197, 197,
                     198, 200, 203, 207, 212, 218, 225, 233, 242, 252, 263, 275};
    int   fy[12] = '{263, 252, 242, 235, 231, 230, 232, 237, 245, 256, 270, 275};

    initial begin
        vec_t v;
        int lc, yc, seg;
        bit ft_state;
        for (int i = 0; i < 25; i++) begin
            v = '{i == 0, 1'b0, jy[i], i < 24, 1'b0, int'(i == 24)};
            tbl.push_back(v);
        end
        v = '{1'b0, 1'b1, GND, 1'b0, 1'b1, 0}; tbl.push_back(v); tbl.push_back(v);
        v = '{1'b1, 1'b1, 263, 1'b1, 1'b0, 0}; tbl.push_back(v);
        for (int i = 1; i < 25; i++) begin
            v = '{1'b0, 1'b0, jy[i], i < 24, 1'b0, int'(i == 24)};
            tbl.push_back(v);
        end
        for (int i = 0; i < 12; i++) begin
            v = '{i == 0, i >= 2, fy[i], i < 11, i == 11, int'(i == 11)};
            tbl.push_back(v);
        end

        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        check("rst_y", int'(dino_y), GND);
        check("rst_x", int'(dino_x), 40);
        check("rst_air", int'(airborne), 0);
        check("rst_duck", int'(ducking), 0);
        check("rst_land", int'(landed), 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, lc, yc);
            check("idle_y", int'(dino_y), GND);
        end

        foreach (tbl[i]) begin
            step(tbl[i].up, tbl[i].dn, lc, yc);
            check($sformatf("vec%0d_y", i), int'(dino_y), tbl[i].y);
            check($sformatf("vec%0d_air", i), int'(airborne), int'(tbl[i].air));
            check($sformatf("vec%0d_duck", i), int'(ducking), int'(tbl[i].duck));
            check($sformatf("vec%0d_land", i), lc, tbl[i].land);
        end

        down = 0;
        up = 1;
        repeat (3) @(negedge clk);
        up = 0;
        repeat (4) @(negedge clk);
        run_frame(100, lc, yc);
        check("long_strobe_steps", yc, 1);
        check("long_strobe_y", int'(dino_y), 263);
        for (int i = 1; i < 5; i++) begin
            run_frame(4, lc, yc);
            check("strobe4_steps", yc, 1);
            check("strobe4_y", int'(dino_y), jy[i]);
        end
        for (int i = 5; i < 25; i++) step(0, 0, lc, yc);
        check("width_land_y", int'(dino_y), GND);
        check("width_land_air", int'(airborne), 0);

        for (int i = 0; i < 6; i++) step(i == 0, 0, lc, yc);
        check("pre_reset_y", int'(dino_y), 218);
        #2 reset = 1;
        #1;
        check("async_rst_y", int'(dino_y), GND);
        check("async_rst_air", int'(airborne), 0);
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 25; i++) begin
            step(i == 0, 0, lc, yc);
            check("rejump_y", int'(dino_y), jy[i]);
        end
        check("rejump_land", lc, 1);

        seg = 0;
        ft_state = 0;
        for (int c = 0; c < 4000; c++) begin
            if (seg == 0) begin
                ft_state = !ft_state;
                if (ft_state) seg = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 40)) : 4;
                else seg = int'($urandom_range(4, 20));
            end
            seg--;
            frame_tick = ft_state;
            if ($urandom_range(0, 29) == 0) up = !up;
            if ($urandom_range(0, 39) == 0) down = !down;
            reset = ($urandom_range(0, 799) == 0);
            @(negedge clk);
            check("rnd_y", int'(dino_y), m_y);
            check("rnd_air", int'(airborne), int'(m_mode == M_RISE || m_mode == M_FALL));
            check("rnd_duck", int'(ducking), int'(m_mode == M_DUCK));
            check("rnd_land", int'(landed), m_land);
        end
        reset = 0; up = 0; down = 0; frame_tick = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
